// File: rtl/data_mem_bridge.sv
// ---------------------------------------------------------------------------
// data_mem_bridge
//
// Connects the single-cycle processor's data-memory port to a word memory
// that answers with a req/ack handshake and a variable latency. The
// processor is stalled through cpu_stall (PC enable = ~cpu_stall) until
// each aligned access finishes. Misaligned accesses, memory timeouts and
// simultaneous read/write requests are reported on sticky error flags.
//
// Parameters
//   TIMEOUT      max REQ cycles to wait for mem_ack (1..65535)
//   ERR_DATA     load data returned for a timed-out read
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous reset, active low
//   cpu_addr     byte address from the ALU
//   cpu_wdata    store data from the register file
//   cpu_rd       load request
//   cpu_wr       store request (wins when cpu_rd is also set)
//   cpu_rdata    load data back to the processor
//   cpu_stall    holds the PC while high
//   mem_req      registered memory request
//   mem_we       1 = write, 0 = read, valid with mem_req
//   mem_addr     word address (cpu_addr[31:2])
//   mem_wdata    write data
//   mem_rdata    read data, valid with mem_ack
//   mem_ack      one-cycle completion strobe
//   misalign_err sticky, access with cpu_addr[1:0] != 0
//   timeout_err  sticky, access abandoned after TIMEOUT cycles
//   conflict_err sticky, cpu_rd and cpu_wr both high
// ---------------------------------------------------------------------------
module data_mem_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        conflict_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The wait counter holds the number of completed REQ cycles without an
    // ack, so it equals TIMEOUT-1 during the last cycle an ack is accepted.
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] wait_cnt;
    logic        access;
    logic        aligned;
    logic        pending;

    // An access is only launched when it is word aligned; misaligned ones
    // are flagged and completed in the same cycle without touching memory.
    always_comb begin
        access  = cpu_rd | cpu_wr;
        aligned = (cpu_addr[1:0] == 2'b00);
        pending = access & aligned;
    end

    // The stall is Mealy so a memory instruction is held in the very cycle
    // it is presented; DONE releases the PC so the instruction retires once.
    always_comb begin
        cpu_stall = 1'b0;
        if (state == REQ)
            cpu_stall = 1'b1;
        else if (state == IDLE && pending)
            cpu_stall = 1'b1;
    end

    // Main FSM with the memory-side registers, load data and sticky flags.
    // A reset while in REQ simply drops the request; an ack arriving outside
    // REQ (late or stray) is never looked at.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= 16'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 30'd0;
            mem_wdata    <= 32'd0;
            cpu_rdata    <= 32'd0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            conflict_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (cpu_rd && cpu_wr)
                            conflict_err <= 1'b1;
                        if (aligned) begin
                            mem_addr  <= cpu_addr[31:2];
                            mem_wdata <= cpu_wdata;
                            mem_we    <= cpu_wr;
                            mem_req   <= 1'b1;
                            wait_cnt  <= 16'd0;
                            state     <= REQ;
                        end else begin
                            misalign_err <= 1'b1;
                            if (!cpu_wr)
                                cpu_rdata <= 32'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            cpu_rdata <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == LAST_WAIT) begin
                            if (!mem_we)
                                cpu_rdata <= ERR_DATA;
                            timeout_err <= 1'b1;
                            mem_req     <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_data_mem_bridge
//
// Directed testbench for data_mem_bridge built with TIMEOUT = 4. Each task
// drives one scenario cycle by cycle and compares outputs against values
// worked out by hand. Inputs change and outputs are sampled 1-2 time units
// after the rising edge, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_data_mem_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        misalign_err;
    logic        timeout_err;
    logic        conflict_err;

    int checks;
    int errors;
    int req_starts;
    logic req_prev;

    data_mem_bridge #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rd       (cpu_rd),
        .cpu_wr       (cpu_wr),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .conflict_err (conflict_err)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges of mem_req so the bench can tell how many
    // separate requests were issued.
    always @(negedge clk) begin
        if (mem_req && !req_prev)
            req_starts = req_starts + 1;
        req_prev = mem_req;
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        tick; tick;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 30'd0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'd0) begin errors++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'd0) begin errors++; $display("[TB] FAIL rst_cpu_rdata: got %h expected 0", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b expected 0", cpu_stall); end
        checks++; if ({misalign_err, timeout_err, conflict_err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags: got %b expected 000", {misalign_err, timeout_err, conflict_err}); end
        // release with an aligned load already presented
        rst = 1'b1; cpu_rd = 1'b1; cpu_addr = 32'h10;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_stall: got %b expected 1", cpu_stall); end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h4) begin errors++; $display("[TB] FAIL rst_first_req: got req %b addr %h expected req 1 addr 4", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001;
        tick;
        mem_ack = 1'b0;
        checks++; if (cpu_rdata !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL rst_first_rdata: got %h expected aaaa0001", cpu_rdata); end
        tick;
        cpu_rd = 1'b0;
    endtask

    task automatic test_load_delayed_ack;
        int starts0;
        starts0 = req_starts;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h0000_0040;
        #1;
        checks++; if (cpu_stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ld_c0: got stall %b req %b expected stall 1 req 0", cpu_stall, mem_req); end
        for (int k = 1; k <= 4; k++) begin
            tick;
            #1;
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h10 || cpu_stall !== 1'b1) begin
                errors++; $display("[TB] FAIL ld_req_c%0d: got req %b we %b addr %h stall %b expected 1 0 10 1", k, mem_req, mem_we, mem_addr, cpu_stall);
            end
            if (k == 4) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
        end
        tick;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ld_rdata: got %h expected 12345678", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL ld_done: got stall %b req %b expected 0 0", cpu_stall, mem_req); end
        tick;
        cpu_rd = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL nonmem_stall: got %b expected 0", cpu_stall); end
        tick;
        checks++; if (req_starts - starts0 !== 1) begin errors++; $display("[TB] FAIL ld_req_count: got %0d expected 1", req_starts - starts0); end
    endtask

    task automatic test_store_immediate_ack;
        cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_addr = 32'h8; cpu_wdata = 32'hCAFE_F00D;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL st_c0_stall: got %b expected 1", cpu_stall); end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h2 || mem_wdata !== 32'hCAFE_F00D || cpu_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL st_c1: got req %b we %b addr %h wdata %h stall %b expected 1 1 2 cafef00d 1", mem_req, mem_we, mem_addr, mem_wdata, cpu_stall);
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_done: got stall %b req %b expected 0 0", cpu_stall, mem_req); end
        checks++; if (cpu_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL st_rdata_kept: got %h expected 12345678", cpu_rdata); end
        tick;
        cpu_wr = 1'b0;
    endtask

    task automatic test_back_to_back;
        cpu_rd = 1'b1; cpu_addr = 32'h100;
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick;
        mem_ack = 1'b0;
        checks++; if (cpu_rdata !== 32'h1111_1111) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 11111111", cpu_rdata); end
        tick;
        cpu_addr = 32'h104;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_stall: got %b expected 1", cpu_stall); end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 30'h41) begin errors++; $display("[TB] FAIL b2b_second_req: got req %b addr %h expected 1 41", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick;
        mem_ack = 1'b0;
        checks++; if (cpu_rdata !== 32'h2222_2222) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 22222222", cpu_rdata); end
        tick;
        cpu_rd = 1'b0;
    endtask

    task automatic test_misaligned_load;
        int starts0;
        starts0 = req_starts;
        cpu_rd = 1'b1; cpu_addr = 32'h6;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_stall: got %b expected 0", cpu_stall); end
        tick;
        cpu_rd = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || misalign_err !== 1'b1 || cpu_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL mis_c1: got req %b err %b rdata %h expected 0 1 0", mem_req, misalign_err, cpu_rdata);
        end
        tick; tick;
        checks++; if (misalign_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_sticky: got err %b req %b expected 1 0", misalign_err, mem_req); end
        checks++; if (req_starts !== starts0) begin errors++; $display("[TB] FAIL mis_no_req: got %0d expected %0d", req_starts, starts0); end
    endtask

    task automatic test_timeout;
        cpu_rd = 1'b1; cpu_addr = 32'h20;
        for (int k = 1; k <= 4; k++) begin
            tick;
            checks++; if (mem_req !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL to_req_c%0d: got req %b err %b expected 1 0", k, mem_req, timeout_err); end
        end
        tick;
        #1;
        checks++; if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("[TB] FAIL to_done: got req %b stall %b expected 0 0", mem_req, cpu_stall); end
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF || timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL to_result: got rdata %h err %b expected deadbeef 1", cpu_rdata, timeout_err); end
        tick;
        cpu_rd = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick;
        mem_ack = 1'b0;
        #1;
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL to_late_ack: got rdata %h req %b stall %b expected deadbeef 0 0", cpu_rdata, mem_req, cpu_stall);
        end
    endtask

    task automatic test_reset_mid_and_conflict;
        cpu_rd = 1'b1; cpu_addr = 32'h30;
        tick;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL rmid_req: got %b expected 1", mem_req); end
        rst = 1'b0; cpu_rd = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || timeout_err !== 1'b0 || misalign_err !== 1'b0) begin
            errors++; $display("[TB] FAIL rmid_after: got req %b to %b mis %b expected 0 0 0", mem_req, timeout_err, misalign_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick;
        mem_ack = 1'b0;
        #1;
        checks++; if (cpu_rdata !== 32'd0 || mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL rmid_stray_ack: got rdata %h req %b stall %b expected 0 0 0", cpu_rdata, mem_req, cpu_stall);
        end
        // both rd and wr: handled as a write
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h0BAD_F00D;
        #1;
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL cf_stall: got %b expected 1", cpu_stall); end
        tick;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 30'h11 || mem_wdata !== 32'h0BAD_F00D || conflict_err !== 1'b1) begin
            errors++; $display("[TB] FAIL cf_req: got req %b we %b addr %h wdata %h cf %b expected 1 1 11 0badf00d 1", mem_req, mem_we, mem_addr, mem_wdata, conflict_err);
        end
        mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
        tick;
        mem_ack = 1'b0;
        checks++; if (cpu_rdata !== 32'd0 || conflict_err !== 1'b1) begin errors++; $display("[TB] FAIL cf_done: got rdata %h cf %b expected 0 1", cpu_rdata, conflict_err); end
        tick;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0; req_starts = 0; req_prev = 1'b0;
        rst = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        test_reset;
        test_load_delayed_ack;
        test_store_immediate_ack;
        test_back_to_back;
        test_misaligned_load;
        test_timeout;
        test_reset_mid_and_conflict;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
